// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver side).
//   tx_state_t : transmitter frame state
//   LINE_IDLE  : level of the line between frames
//   START_BIT  : level of the start bit
//   STOP_BIT   : level of the stop bit
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clocks while run is high and flags the last clock of each bit period.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   run   : count enable; counter is cleared whenever run is low
//   tick  : high on the final clock of a CLKS_PER_BIT-long bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // With CLKS_PER_BIT == 1 LAST is 0, so the counter sits at 0 and tick follows run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!run || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: frames a parallel word as start bit, DATA_W data bits (LSB first) and
// stop bit on an idle-high line, each bit held for CLKS_PER_BIT clocks.
//   clk        : system clock
//   reset      : asynchronous active-low reset; aborts any frame and forces tx high
//   data_in    : word to send, sampled only on the valid/ready handshake
//   data_valid : upstream offers a word
//   data_ready : block is idle and will accept a word this cycle
//   tx         : registered serial line
//   busy       : a frame is in flight
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_idx_q;
  logic              tx_q;
  logic              tick;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  assign shift_next = shift_q >> 1;

  // tx is loaded one state ahead so the line level is always a flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_valid) begin
            shift_q <= data_in;
            state_q <= START;
            tx_q    <= START_BIT;
          end
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_next;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= STOP_BIT;
            end else begin
              bit_idx_q <= bit_idx_q + BW'(1);
              tx_q      <= shift_next[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = !data_ready;
  assign tx         = tx_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: two instances (CLKS_PER_BIT 4 and 1). Each accepted word
// pushes its expected line levels, one entry per clock, into a queue; a monitor pops one entry
// per busy cycle and compares it with tx.
module tb_serial_tx;

  localparam int DW    = 8;
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b;
  logic          ready_a, ready_b;
  logic          tx_a, tx_b;
  logic          busy_a, busy_b;

  int vectors     = 0;
  int miscompares = 0;

  logic q_a[$];
  logic q_b[$];

  // Monitor bookkeeping (lengths of the last busy run and of the last idle gap).
  logic prev_busy_a = 1'b0, prev_busy_b = 1'b0;
  int   busy_len_a = 0, busy_len_b = 0;
  int   last_len_a = 0, last_len_b = 0;
  int   idle_len_a = 0, last_gap_a = 0;

  serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB_A)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .tx         (tx_a),
    .busy       (busy_a)
  );

  serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB_B)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .tx         (tx_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the n-th next rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      // instance A
      if (busy_a) begin
        chk("a_ready_low_while_busy", {31'd0, ready_a}, 32'd1 - 32'd1);
        chk("a_frame_expected", {31'd0, (q_a.size() > 0)}, 32'd1);
        if (q_a.size() > 0) chk("a_tx", {31'd0, tx_a}, {31'd0, q_a.pop_front()});
        if (!prev_busy_a) begin
          last_gap_a = idle_len_a;
          busy_len_a = 0;
        end
        busy_len_a++;
        idle_len_a = 0;
      end else begin
        chk("a_idle_tx", {31'd0, tx_a}, 32'd1);
        chk("a_idle_ready", {31'd0, ready_a}, 32'd1);
        chk("a_frame_drained", 32'(q_a.size()), 32'd0);
        if (prev_busy_a) last_len_a = busy_len_a;
        idle_len_a++;
      end
      prev_busy_a = busy_a;
      // instance B
      if (busy_b) begin
        chk("b_frame_expected", {31'd0, (q_b.size() > 0)}, 32'd1);
        if (q_b.size() > 0) chk("b_tx", {31'd0, tx_b}, {31'd0, q_b.pop_front()});
        if (!prev_busy_b) busy_len_b = 0;
        busy_len_b++;
      end else begin
        chk("b_idle_tx", {31'd0, tx_b}, 32'd1);
        chk("b_idle_ready", {31'd0, ready_b}, 32'd1);
        chk("b_frame_drained", 32'(q_b.size()), 32'd0);
        if (prev_busy_b) last_len_b = busy_len_b;
      end
      prev_busy_b = busy_b;
    end
  endtask

  // Frame model: start 0, data LSB first, stop 1, each level repeated cpb times.
  task automatic push_frame(input bit sel_b, input logic [DW-1:0] w, input int cpb);
    logic lvl;
    for (int b = 0; b < DW + 2; b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b == DW + 1) lvl = 1'b1;
      else lvl = w[b-1];
      for (int c = 0; c < cpb; c++) begin
        if (sel_b) q_b.push_back(lvl);
        else q_a.push_back(lvl);
      end
    end
  endtask

  task automatic send_a(input logic [DW-1:0] w, input bit keep_valid);
    bit accepted = 1'b0;
    int n = 0;
    data_a  = w;
    valid_a = 1'b1;
    while (!accepted && n < 300) begin
      if (ready_a) begin
        step(1);
        accepted = 1'b1;
        push_frame(1'b0, w, CPB_A);
      end else begin
        step(1);
        n++;
      end
    end
    chk("a_accept_timeout", {31'd0, accepted}, 32'd1);
    if (!keep_valid) valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [DW-1:0] w);
    bit accepted = 1'b0;
    int n = 0;
    data_b  = w;
    valid_b = 1'b1;
    while (!accepted && n < 100) begin
      if (ready_b) begin
        step(1);
        accepted = 1'b1;
        push_frame(1'b1, w, CPB_B);
      end else begin
        step(1);
        n++;
      end
    end
    chk("b_accept_timeout", {31'd0, accepted}, 32'd1);
    valid_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 300 && busy_a; i++) step(1);
    chk("a_idle_timeout", {31'd0, busy_a}, 32'd0);
    step(1);
  endtask

  task automatic wait_idle_b();
    for (int i = 0; i < 100 && busy_b; i++) step(1);
    chk("b_idle_timeout", {31'd0, busy_b}, 32'd0);
    step(1);
  endtask

  initial begin
    logic [DW-1:0] w;
    reset   = 1'b0;
    data_a  = '0;
    data_b  = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    fork
      monitor();
    join_none

    step(3);
    chk("rst_tx", {31'd0, tx_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    reset = 1'b1;
    step(20);

    // Single frame 0xA5.
    send_a(8'hA5, 1'b0);
    wait_idle_a();
    chk("a5_busy_len", 32'(last_len_a), 32'd40);

    // Valid pulse with 0x3C during the data bits must be ignored.
    send_a(8'hA5, 1'b0);
    step(8);
    data_a  = 8'h3C;
    valid_a = 1'b1;
    chk("ignored_ready", {31'd0, ready_a}, 32'd0);
    step(2);
    valid_a = 1'b0;
    data_a  = 8'h00;
    wait_idle_a();
    chk("ignored_busy_len", 32'(last_len_a), 32'd40);

    // Back-to-back with valid held high.
    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b0);
    wait_idle_a();
    chk("b2b_idle_gap", 32'(last_gap_a), 32'd1);
    chk("b2b_busy_len", 32'(last_len_a), 32'd40);

    // Asynchronous reset during data bit 3, between clock edges.
    send_a(8'h5C, 1'b0);
    step(17);
    #2;
    reset = 1'b0;
    q_a.delete();
    #1;
    chk("abort_tx", {31'd0, tx_a}, 32'd1);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ready", {31'd0, ready_a}, 32'd1);
    step(2);
    reset = 1'b1;
    step(2);
    send_a(8'h81, 1'b0);
    wait_idle_a();
    chk("after_abort_len", 32'(last_len_a), 32'd40);

    // Randomized frames; data_in is scrambled while busy.
    for (int i = 0; i < 12; i++) begin
      w = DW'($urandom);
      send_a(w, 1'b0);
      data_a = DW'($urandom);
      step($urandom_range(0, 50));
      data_a = DW'($urandom);
      wait_idle_a();
      step($urandom_range(0, 4));
    end

    // One clock per bit.
    send_b(8'h5A);
    wait_idle_b();
    chk("b_5a_busy_len", 32'(last_len_b), 32'd10);
    for (int i = 0; i < 8; i++) begin
      send_b(DW'($urandom));
      data_b = DW'($urandom);
      wait_idle_b();
    end

    step(5);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Serial transmitter that serialises a parallel word into an idle-high, start/data/stop framed bitstream, LSB first. It is the sending end of the single-wire serial link whose capture side is built from our flip-flop/shift-register receivers. Upstream logic hands words in over a valid/ready handshake. The block drives the line for a fixed number of clocks per bit.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (>=1)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_in  input  DATA_W  word to transmit, sampled only on handshake
data_valid  input  1  upstream has a word on data_in
data_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in flight (START/DATA/STOP)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, busy=0, data_ready=1.
  - Shift register, bit counter and clock counter cleared.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock edge.
- States: IDLE, START, DATA, STOP.
- data_ready = (state==IDLE), decoded combinationally from the state register. busy = !data_ready.
- Handshake: accept on a rising edge with data_valid=1 and data_ready=1.
  - data_in is latched into the shift register.
  - Next state START; tx=0 from the cycle after acceptance (1-cycle latency).
- data_valid while busy: ignored. data_in changes while busy: no effect on the frame.
- Clock counter: width $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Counts 0..CLKS_PER_BIT-1 in each non-IDLE state; a bit period ends on terminal count.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit DATA_W-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles of busy=1.
- Back-to-back frames: minimum gap between the end of one frame's data bits and the next start bit is CLKS_PER_BIT+1 cycles of tx=1 (the stop bit plus 1 IDLE cycle for the handshake).
- CLKS_PER_BIT=1: each bit is one cycle, no counter wrap issues. The counter is held at 0 and the terminal count is always true.
- tx never glitches: it is driven from a flop, never decoded combinationally.

Decomposition:
- Package serial_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Line level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - Shared with the receiver side.
- One sub-module, bit_timer: parameter CLKS_PER_BIT; inputs clk, reset, run; output tick (terminal count).
  - Counter clears whenever run=0.
  - Reused by the receiver.

Test Plan:
- Reset then idle, no valid: tx=1, busy=0, data_ready=1 for 20 cycles.
- Send 0xA5 (DATA_W=8, CLKS_PER_BIT=4):
  - tx is 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held exactly 4 cycles.
  - busy=1 for exactly 40 cycles; start bit begins 1 cycle after the handshake.
- Back-to-back 0x00 then 0xFF, with data_valid held high:
  - Second word accepted on the first IDLE cycle after the stop bit.
  - tx high for exactly 5 cycles between frames.
  - Second frame is start 0, eight 1s, stop 1.
- data_valid pulsed with 0x3C during the DATA state of the 0xA5 frame: ignored; the 0xA5 waveform is unchanged and data_ready stays 0.
- reset driven low during bit 3 of a frame, between clock edges:
  - tx=1 and busy=0 immediately.
  - After release, the next accepted 0x81 produces a clean full frame.
- Instance with CLKS_PER_BIT=1 sending 0x5A: tx per cycle is 0,0,1,0,1,1,0,1,0,1; busy high for 10 cycles.
